// File: rtl/cluster_tx_serializer.sv
// Captures a sorted 8-cluster frame per mux_pulse and streams it
// two clusters per beat under valid/ready, stopping at the first empty slot.
module cluster_tx_serializer #(
  parameter int MXADRBITS   = 11,
  parameter int MXCNTBITS   = 3,
  parameter int MXCLUSTERS  = 8,
  parameter int INVALID_ADR = 2047,
  parameter bit SEND_EMPTY  = 1'b0
) (
  input  logic                            clock4x,
  input  logic                            reset,
  input  logic                            mux_pulse_in,
  input  logic [MXCLUSTERS*MXADRBITS-1:0] adr_in,
  input  logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in,
  input  logic                            tx_ready,
  output logic                            tx_valid,
  output logic                            tx_sof,
  output logic                            tx_eof,
  output logic [MXADRBITS-1:0]            tx_adr0,
  output logic [MXCNTBITS-1:0]            tx_cnt0,
  output logic [MXADRBITS-1:0]            tx_adr1,
  output logic [MXCNTBITS-1:0]            tx_cnt1,
  output logic                            busy,
  output logic                            frame_dropped,
  output logic [7:0]                      overflow_cnt
);

  localparam int NB = $clog2(MXCLUSTERS + 1);
  localparam int KB = $clog2(MXCLUSTERS / 2);
  localparam logic [MXADRBITS-1:0] INV = MXADRBITS'(INVALID_ADR);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_n;

  logic [MXADRBITS-1:0] slot_adr [MXCLUSTERS];
  logic [MXCNTBITS-1:0] slot_cnt [MXCLUSTERS];
  logic [MXADRBITS-1:0] adr_q [MXCLUSTERS];
  logic [MXCNTBITS-1:0] cnt_q [MXCLUSTERS];

  logic [NB-1:0] nvalid_in, nvalid_q;
  logic [KB:0]   nbeats_in, nbeats_q;
  logic [KB-1:0] k_q;
  logic [KB:0]   idx0, idx1;
  logic          stop;
  logic          send, fire, last, done;
  logic          capture, drop, has_data;

  always_comb begin
    nvalid_in = '0;
    stop      = 1'b0;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      slot_adr[i] = adr_in[i*MXADRBITS +: MXADRBITS];
      slot_cnt[i] = cnt_in[i*MXCNTBITS +: MXCNTBITS];
      if (!stop && slot_adr[i] != INV)
        nvalid_in = nvalid_in + NB'(1);
      else
        stop = 1'b1;
    end
  end

  // An empty frame sent with SEND_EMPTY still occupies one beat
  assign nbeats_in = (nvalid_in == '0) ? (KB+1)'(1)
                   : (KB+1)'((nvalid_in + NB'(1)) >> 1);
  assign has_data  = (nvalid_in != '0) || SEND_EMPTY;

  assign send    = (state == SEND);
  assign fire    = send && tx_ready;
  assign last    = ({1'b0, k_q} == nbeats_q - (KB+1)'(1));
  assign done    = fire && last;
  assign capture = mux_pulse_in && (!send || done);
  assign drop    = mux_pulse_in && send && !done;

  always_ff @(posedge clock4x) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (capture)   state_n = has_data ? SEND : IDLE;
    else if (done) state_n = IDLE;
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      for (int i = 0; i < MXCLUSTERS; i++) begin
        adr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      nvalid_q      <= '0;
      nbeats_q      <= '0;
      k_q           <= '0;
      frame_dropped <= 1'b0;
      overflow_cnt  <= '0;
    end else begin
      frame_dropped <= drop;
      if (drop && overflow_cnt != 8'hff)
        overflow_cnt <= overflow_cnt + 8'd1;
      if (capture) begin
        for (int i = 0; i < MXCLUSTERS; i++) begin
          adr_q[i] <= slot_adr[i];
          cnt_q[i] <= slot_cnt[i];
        end
        nvalid_q <= nvalid_in;
        nbeats_q <= nbeats_in;
        k_q      <= '0;
      end else if (fire && !last) begin
        k_q <= k_q + KB'(1);
      end
    end
  end

  assign idx0 = {k_q, 1'b0};
  assign idx1 = {k_q, 1'b1};

  always_comb begin
    tx_valid = send;
    tx_sof   = send && (k_q == '0);
    tx_eof   = send && last;
    busy     = send;
    tx_adr0  = '0;
    tx_cnt0  = '0;
    tx_adr1  = '0;
    tx_cnt1  = '0;
    if (send) begin
      tx_adr0 = INV;
      tx_adr1 = INV;
      if (NB'(idx0) < nvalid_q) begin
        tx_adr0 = adr_q[idx0];
        tx_cnt0 = cnt_q[idx0];
      end
      if (NB'(idx1) < nvalid_q) begin
        tx_adr1 = adr_q[idx1];
        tx_cnt1 = cnt_q[idx1];
      end
    end
  end

endmodule

// File: tb/tb_cluster_tx_serializer.sv
// Directed bench for cluster_tx_serializer; a second instance
// covers the SEND_EMPTY=1 build on the same stimulus.
module tb_cluster_tx_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pulse;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic        ready;

  logic        tx_valid, tx_sof, tx_eof, busy, frame_dropped;
  logic [10:0] tx_adr0, tx_adr1;
  logic [2:0]  tx_cnt0, tx_cnt1;
  logic [7:0]  overflow_cnt;

  logic        e_valid, e_sof, e_eof, e_busy, e_dropped;
  logic [10:0] e_adr0, e_adr1;
  logic [2:0]  e_cnt0, e_cnt1;
  logic [7:0]  e_ovf;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cluster_tx_serializer dut (
    .clock4x(clk), .reset(reset), .mux_pulse_in(pulse),
    .adr_in(adr_in), .cnt_in(cnt_in), .tx_ready(ready),
    .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .tx_adr0(tx_adr0), .tx_cnt0(tx_cnt0),
    .tx_adr1(tx_adr1), .tx_cnt1(tx_cnt1),
    .busy(busy), .frame_dropped(frame_dropped),
    .overflow_cnt(overflow_cnt)
  );

  cluster_tx_serializer #(.SEND_EMPTY(1'b1)) dut_e (
    .clock4x(clk), .reset(reset), .mux_pulse_in(pulse),
    .adr_in(adr_in), .cnt_in(cnt_in), .tx_ready(ready),
    .tx_valid(e_valid), .tx_sof(e_sof), .tx_eof(e_eof),
    .tx_adr0(e_adr0), .tx_cnt0(e_cnt0),
    .tx_adr1(e_adr1), .tx_cnt1(e_cnt1),
    .busy(e_busy), .frame_dropped(e_dropped),
    .overflow_cnt(e_ovf)
  );

  logic [31:0] obs, obs_e;
  assign obs = {1'b0, tx_valid, tx_sof, tx_eof,
                tx_adr0, tx_cnt0, tx_adr1, tx_cnt1};
  assign obs_e = {1'b0, e_valid, e_sof, e_eof,
                  e_adr0, e_cnt0, e_adr1, e_cnt1};

  function automatic logic [31:0] bt(
    input logic v, input logic s, input logic e,
    input logic [10:0] a0, input logic [2:0] c0,
    input logic [10:0] a1, input logic [2:0] c1);
    return {1'b0, v, s, e, a0, c0, a1, c1};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame_a();
    for (int i = 0; i < 8; i++) begin
      adr_in[i*11 +: 11] = 11'(10 * (i + 1));
      cnt_in[i*3 +: 3]   = 3'(i + 1);
    end
  endtask

  task automatic frame_odd();
    adr_in = {8{11'd2047}};
    cnt_in = {8{3'd6}};
    adr_in[0*11 +: 11] = 11'd5;   cnt_in[0*3 +: 3] = 3'd1;
    adr_in[1*11 +: 11] = 11'd9;   cnt_in[1*3 +: 3] = 3'd2;
    adr_in[2*11 +: 11] = 11'd300; cnt_in[2*3 +: 3] = 3'd3;
    adr_in[5*11 +: 11] = 11'd400; cnt_in[5*3 +: 3] = 3'd4;
  endtask

  logic [31:0] a0, a1, a2, a3, o0, o1;

  initial begin
    a0 = bt(1'b1, 1'b1, 1'b0, 11'd10, 3'd1, 11'd20, 3'd2);
    a1 = bt(1'b1, 1'b0, 1'b0, 11'd30, 3'd3, 11'd40, 3'd4);
    a2 = bt(1'b1, 1'b0, 1'b0, 11'd50, 3'd5, 11'd60, 3'd6);
    a3 = bt(1'b1, 1'b0, 1'b1, 11'd70, 3'd7, 11'd80, 3'd0);
    o0 = bt(1'b1, 1'b1, 1'b0, 11'd5, 3'd1, 11'd9, 3'd2);
    o1 = bt(1'b1, 1'b0, 1'b1, 11'd300, 3'd3, 11'd2047, 3'd0);
    reset = 1'b1; pulse = 1'b0; ready = 1'b0;
    adr_in = '0; cnt_in = '0;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    check("rst_out", obs, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);

    // full frame
    frame_a(); pulse = 1'b1; ready = 1'b1; step(); pulse = 1'b0;
    check("full0", obs, a0);
    check("full_busy", 32'(busy), 32'd1);
    step(); check("full1", obs, a1);
    step(); check("full2", obs, a2);
    step(); check("full3", obs, a3);
    step(); check("full_idle", obs, 32'd0);
    check("full_nbusy", 32'(busy), 32'd0);

    // odd count, slot after a hole ignored
    frame_odd(); pulse = 1'b1; step(); pulse = 1'b0;
    check("odd0", obs, o0);
    step(); check("odd1", obs, o1);
    step(); check("odd_idle", obs, 32'd0);

    // empty frame
    adr_in = {8{11'd2047}}; cnt_in = {8{3'd5}};
    pulse = 1'b1; step(); pulse = 1'b0;
    check("empty0", obs, 32'd0);
    check("empty_e0", obs_e,
          bt(1'b1, 1'b1, 1'b1, 11'd2047, 3'd0, 11'd2047, 3'd0));
    step();
    check("empty1", obs, 32'd0);
    check("empty_e1", obs_e, 32'd0);

    // backpressure at beat 1
    frame_a(); pulse = 1'b1; step(); pulse = 1'b0;
    check("bp0", obs, a0);
    step(); check("bp1", obs, a1);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check("bp_hold", obs, a1);
    end
    ready = 1'b1;
    step(); check("bp2", obs, a2);
    step(); check("bp3", obs, a3);
    step(); check("bp_idle", obs, 32'd0);

    // single drop while stalled
    ready = 1'b0; frame_a(); pulse = 1'b1; step(); pulse = 1'b0;
    check("ov0", obs, a0);
    step(); step(); step();
    for (int i = 0; i < 8; i++) adr_in[i*11 +: 11] = 11'(100 + i);
    pulse = 1'b1; step(); pulse = 1'b0;
    check("ov_drop", 32'(frame_dropped), 32'd1);
    check("ov_cnt", 32'(overflow_cnt), 32'd1);
    check("ov_hold", obs, a0);
    step();
    check("ov_pulse1", 32'(frame_dropped), 32'd0);
    ready = 1'b1;
    step(); check("ov1", obs, a1);
    step(); check("ov2", obs, a2);
    step(); check("ov3", obs, a3);
    step(); check("ov_idle", obs, 32'd0);

    // saturation
    ready = 1'b0; frame_a(); pulse = 1'b1; step();
    repeat (300) step();
    pulse = 1'b0;
    check("sat_cnt", 32'(overflow_cnt), 32'd255);
    check("sat_beat", obs, a0);
    ready = 1'b1;
    step(); step(); step(); step();
    check("sat_idle", obs, 32'd0);

    // capture on eof-accept cycle
    frame_a(); pulse = 1'b1; step(); pulse = 1'b0;
    step(); step(); step();
    check("b2b_eof", obs, a3);
    frame_odd(); pulse = 1'b1; step(); pulse = 1'b0;
    check("b2b_sof", obs, o0);
    check("b2b_nodrop", 32'(frame_dropped), 32'd0);
    step(); check("b2b_1", obs, o1);
    step(); check("b2b_idle", obs, 32'd0);

    // reset mid-frame, pulse during reset ignored
    frame_a(); pulse = 1'b1; step(); pulse = 1'b0;
    step(); step();
    check("mr_beat2", obs, a2);
    reset = 1'b1; pulse = 1'b1; step();
    reset = 1'b0; pulse = 1'b0;
    check("mr_out", obs, 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_ovf", 32'(overflow_cnt), 32'd0);
    step(); check("mr_still", obs, 32'd0);
    pulse = 1'b1; step(); pulse = 1'b0;
    check("mr_sof", obs, a0);
    step(); step(); step();
    check("mr_eof", obs, a3);
    step(); check("mr_idle", obs, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
